stack_pop_sequencer: RTL and testbench
======================================

# stack_pop_sequencer

Multi-cycle sequencer that pops the saved PC (and, for RTI, the saved flags) off the descending data stack and redirects fetch. It is the return-side counterpart of the push sequencer used by CALL/INT. It sits between decode (RET/RTI requests), the data-memory read port, the SP register and the PC/flags registers. It stalls the pipeline for the whole sequence.

## Interface
- DATA_WIDTH, 16, stack word width; the PC is two words.
- SP_WIDTH, 11, stack pointer / memory address width.
- FLAG_WIDTH, 4, flag bits restored from the low bits of the flags word.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ret_req  input  1  RET decoded; pop PC only.
- rti_req  input  1  RTI decoded; pop flags, then PC.
- sp_in  input  SP_WIDTH  current SP; points to the next free slot (full-descending stack).
- mem_rd_req  output  1  read request to data memory.
- mem_rd_addr  output  SP_WIDTH  read address.
- mem_rd_data  input  DATA_WIDTH  read data, valid when mem_rd_valid=1.
- mem_rd_valid  input  1  read completion; may be high in the same cycle as mem_rd_req.
- stall  output  1  freezes fetch/decode while busy.
- pc_load  output  1  one-cycle strobe: load pc_out into PC.
- pc_out  output  2*DATA_WIDTH  restored PC, {hi,lo}.
- flags_load  output  1  one-cycle strobe: load flags_out (RTI only).
- flags_out  output  FLAG_WIDTH  restored flags.
- sp_we  output  1  one-cycle strobe: write sp_out to SP.
- sp_out  output  SP_WIDTH  final SP after pops.
- underflow_err  output  1  one-cycle pulse on stack underflow (only with the macro defined).

## Operation
- States: IDLE, POP_FLAGS, POP_PC_HI, POP_PC_LO, REDIRECT.
- IDLE, rti_req=1: capture sp_in into sp_q, set is_rti, go to POP_FLAGS.
- IDLE, ret_req=1 only: capture sp_in into sp_q, clear is_rti, go to POP_PC_HI.
- Both requests high at once: RTI wins.
- Requests outside IDLE are ignored.
- Each POP state:
  - Drive mem_rd_req=1 and mem_rd_addr=sp_q+1 (mod 2^SP_WIDTH).
  - Hold the state until mem_rd_valid=1.
  - On valid: capture the word, sp_q<=sp_q+1, advance.
- Capture and sequencing:
  - POP_FLAGS: flags_q<=mem_rd_data[FLAG_WIDTH-1:0]; next POP_PC_HI.
  - POP_PC_HI: pc_q[31:16]<=data; next POP_PC_LO.
  - POP_PC_LO: pc_q[15:0]<=data; next REDIRECT.
- REDIRECT:
  - Drive pc_load=1, sp_we=1, and flags_load=is_rti for exactly one cycle.
  - pc_out, flags_out and sp_out are driven from the registers.
  - Next state IDLE.
- stall=1 in every non-IDLE state, including REDIRECT; stall=0 in IDLE.
- Outputs are decoded from the registered state. pc_out, flags_out and sp_out hold their last value in IDLE.
- Reset (asynchronous, any state):
  - State goes to IDLE; sp_q, pc_q, flags_q and is_rti clear to 0.
  - All outputs are 0: stall, mem_rd_req, pc_load, flags_load, sp_we, underflow_err.
  - A sequence interrupted by reset is abandoned: no pc_load and no SP write.

## Timing
- Request sampled at edge T; first POP state occupies cycle T+1.
- With zero-wait memory (mem_rd_valid high with the request):
  - RET: POP_PC_HI T+1, POP_PC_LO T+2, REDIRECT T+3; stall high for 3 cycles.
  - RTI: POP_FLAGS T+1, POP_PC_HI T+2, POP_PC_LO T+3, REDIRECT T+4; stall high for 4 cycles.
- Each cycle with mem_rd_valid=0 in a POP state adds one cycle. mem_rd_req and mem_rd_addr stay stable while waiting.
- Back-to-back: a request present in the cycle after REDIRECT (IDLE) is accepted normally.

## Configuration
- STACK_UNDERFLOW_CHECK_EN defined:
  - On entry to any POP state with sp_q==2^SP_WIDTH-1, do not issue mem_rd_req.
  - Pulse underflow_err=1 for that cycle and return to IDLE.
  - No pc_load, flags_load or sp_we.
- Not defined:
  - The check logic is absent; underflow_err is tied 0.
  - SP and address wrap modulo 2^SP_WIDTH (0x7FF+1 -> 0x000).

## Test plan
- Reset mid-sequence:
  - Stimulus: start RET, memory stalled in POP_PC_HI, pull rst_n low asynchronously.
  - Required: all outputs 0 immediately; no pc_load/sp_we after release.
- RET, zero-wait:
  - Stimulus: sp_in=0x7FD, mem[0x7FE]=0x0000, mem[0x7FF]=0x0123.
  - Required: addresses 0x7FE then 0x7FF; pc_load at T+3 with pc_out=0x00000123, sp_out=0x7FF; stall high exactly 3 cycles; flags_load=0.
- RTI:
  - Stimulus: sp_in=0x7FC, mem[0x7FD]=0x0005, mem[0x7FE]=0x0001, mem[0x7FF]=0x0040.
  - Required: flags_out=0x5, pc_out=0x00010040, sp_out=0x7FF; pc_load, flags_load and sp_we together at T+4.
- Wait states:
  - Stimulus: RTI with mem_rd_valid low for 2 cycles on each pop.
  - Required: REDIRECT at T+10; address held stable while waiting; final values as in the RTI test.
- Simultaneous requests:
  - Stimulus: ret_req=rti_req=1, then new requests while busy.
  - Required: RTI sequence runs; mid-sequence requests are ignored.
- Underflow:
  - Stimulus: sp_in=0x7FE, RET.
  - Required with the macro: PC_HI read at 0x7FF, then underflow_err pulse, no pc_load.
  - Required without the macro: second read at 0x000, pc_load with sp_out=0x000.

Source files
------------

// File: rtl/stack_pop_sequencer.sv
// Return-side stack sequencer: pops flags (RTI) and the two-word PC, then redirects fetch.
// Optional feature: define STACK_UNDERFLOW_CHECK_EN to abort pops that would read past the stack top.
module stack_pop_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SP_WIDTH   = 11,
    parameter int unsigned FLAG_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ret_req,
    input  logic                      rti_req,
    input  logic [SP_WIDTH-1:0]       sp_in,
    output logic                      mem_rd_req,
    output logic [SP_WIDTH-1:0]       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    input  logic                      mem_rd_valid,
    output logic                      stall,
    output logic                      pc_load,
    output logic [2*DATA_WIDTH-1:0]   pc_out,
    output logic                      flags_load,
    output logic [FLAG_WIDTH-1:0]     flags_out,
    output logic                      sp_we,
    output logic [SP_WIDTH-1:0]       sp_out,
    output logic                      underflow_err
);

    localparam int unsigned PC_WIDTH = 2 * DATA_WIDTH;
    localparam logic [SP_WIDTH-1:0] SP_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        POP_FLAGS,
        POP_PC_HI,
        POP_PC_LO,
        REDIRECT
    } state_t;

    state_t                state_q, state_d;
    logic [SP_WIDTH-1:0]   sp_q, sp_d, sp_inc;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic                  is_rti_q, is_rti_d;
    logic                  pop_d;
    logic                  uf_d;

    assign sp_inc = sp_q + SP_WIDTH'(1);

    // Next-state and datapath capture; underflow_err marks a POP state entered at the stack top.
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        pc_d     = pc_q;
        flags_d  = flags_q;
        is_rti_d = is_rti_q;
        unique case (state_q)
            IDLE: begin
                if (rti_req) begin
                    sp_d     = sp_in;
                    is_rti_d = 1'b1;
                    state_d  = POP_FLAGS;
                end else if (ret_req) begin
                    sp_d     = sp_in;
                    is_rti_d = 1'b0;
                    state_d  = POP_PC_HI;
                end
            end
            POP_FLAGS: begin
                if (underflow_err) begin
                    state_d = IDLE;
                end else if (mem_rd_valid) begin
                    flags_d = mem_rd_data[FLAG_WIDTH-1:0];
                    sp_d    = sp_inc;
                    state_d = POP_PC_HI;
                end
            end
            POP_PC_HI: begin
                if (underflow_err) begin
                    state_d = IDLE;
                end else if (mem_rd_valid) begin
                    pc_d[PC_WIDTH-1:DATA_WIDTH] = mem_rd_data;
                    sp_d    = sp_inc;
                    state_d = POP_PC_LO;
                end
            end
            POP_PC_LO: begin
                if (underflow_err) begin
                    state_d = IDLE;
                end else if (mem_rd_valid) begin
                    pc_d[DATA_WIDTH-1:0] = mem_rd_data;
                    sp_d    = sp_inc;
                    state_d = REDIRECT;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign pop_d = (state_d == POP_FLAGS) || (state_d == POP_PC_HI) || (state_d == POP_PC_LO);

`ifdef STACK_UNDERFLOW_CHECK_EN
    assign uf_d = pop_d && (sp_d == SP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else begin
            underflow_err <= uf_d;
        end
    end
`else
    assign uf_d          = 1'b0;
    assign underflow_err = 1'b0;
`endif

    // State, datapath and strobes; strobes are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            pc_q        <= '0;
            flags_q     <= '0;
            is_rti_q    <= 1'b0;
            stall       <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            pc_load     <= 1'b0;
            flags_load  <= 1'b0;
            sp_we       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            is_rti_q    <= is_rti_d;
            stall       <= (state_d != IDLE);
            mem_rd_req  <= pop_d && !uf_d;
            mem_rd_addr <= sp_d + SP_WIDTH'(1);
            pc_load     <= (state_d == REDIRECT);
            flags_load  <= (state_d == REDIRECT) && is_rti_d;
            sp_we       <= (state_d == REDIRECT);
        end
    end

    assign pc_out    = pc_q;
    assign flags_out = flags_q;
    assign sp_out    = sp_q;

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Self-checking bench for stack_pop_sequencer: directed scenarios plus randomized RET/RTI
// sequences checked against a queue-based stack model.
`timescale 1ns/1ps
module tb_stack_pop_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 11;
    localparam int unsigned FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ret_req = 1'b0;
    logic          rti_req = 1'b0;
    logic [SW-1:0] sp_in = '0;
    logic          mem_rd_req;
    logic [SW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_valid = 1'b0;
    logic          stall, pc_load, flags_load, sp_we, underflow_err;
    logic [2*DW-1:0] pc_out;
    logic [FW-1:0] flags_out;
    logic [SW-1:0] sp_out;

    always #5 clk = ~clk;

    stack_pop_sequencer #(.DATA_WIDTH(DW), .SP_WIDTH(SW), .FLAG_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n), .ret_req(ret_req), .rti_req(rti_req), .sp_in(sp_in),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .stall(stall), .pc_load(pc_load), .pc_out(pc_out),
        .flags_load(flags_load), .flags_out(flags_out), .sp_we(sp_we), .sp_out(sp_out),
        .underflow_err(underflow_err)
    );

    logic [DW-1:0] mem [0:2047];
    int checks = 0;
    int errors = 0;

    // Observations of one sequence
    logic [SW-1:0] obs_addrs[$];
    bit            addr_stable;
    int            load_cyc, load_cnt, we_cnt, fl_cnt, uf_cyc, stall_cnt;
    logic [31:0]   obs_pc;
    logic [FW-1:0] obs_flags;
    logic [SW-1:0] obs_sp;
    logic          obs_fl, obs_we;

    // Expectations from the model
    logic [SW-1:0] exp_addrs[$];
    bit            exp_uf;
    int            exp_end;
    logic [31:0]   exp_pc;
    logic [FW-1:0] exp_flags;
    logic [SW-1:0] exp_sp;

    // Stack model: n pops upward from sp; each pop costs (waits+1) cycles, then one redirect cycle.
    function automatic void model(input logic rti, input logic [SW-1:0] sp, input int waits);
        int n = rti ? 3 : 2;
        logic [SW-1:0] s = sp;
        logic [DW-1:0] w [3];
        for (int k = 0; k < 3; k++) w[k] = '0;
        exp_addrs.delete();
        exp_uf = 0;
        for (int k = 0; k < n; k++) begin
`ifdef STACK_UNDERFLOW_CHECK_EN
            if (s == 11'h7FF) begin
                exp_uf = 1;
                break;
            end
`endif
            s = s + 11'd1;
            exp_addrs.push_back(s);
            w[k] = mem[s];
        end
        exp_sp    = s;
        exp_end   = exp_addrs.size() * (waits + 1) + 1;
        exp_flags = rti ? w[0][FW-1:0] : '0;
        exp_pc    = rti ? {w[1], w[2]} : {w[0], w[1]};
    endfunction

    // Issues one request and services memory until the DUT drops stall (bounded).
    task automatic run_seq(input logic rti, input logic ret, input logic [SW-1:0] sp,
                           input int waits, input bit poke);
        int cyc = 1;
        int wcnt = 0;
        logic [SW-1:0] last_addr = '0;
        obs_addrs.delete();
        addr_stable = 1; load_cyc = -1; load_cnt = 0; we_cnt = 0; fl_cnt = 0;
        uf_cyc = -1; stall_cnt = 0; obs_pc = '0; obs_flags = '0; obs_sp = '0;
        obs_fl = 1'b0; obs_we = 1'b0;
        @(negedge clk);
        rti_req = rti; ret_req = ret; sp_in = sp;
        @(posedge clk); #1;
        rti_req = 1'b0; ret_req = 1'b0; sp_in = SW'($urandom);
        while (cyc <= 60) begin
            if (!stall) break;
            stall_cnt++;
            if (pc_load) begin
                if (load_cyc < 0) begin
                    load_cyc = cyc; obs_pc = pc_out; obs_flags = flags_out; obs_sp = sp_out;
                    obs_fl = flags_load; obs_we = sp_we;
                end
                load_cnt++;
            end
            if (sp_we) we_cnt++;
            if (flags_load) fl_cnt++;
            if (underflow_err && uf_cyc < 0) uf_cyc = cyc;
            if (mem_rd_req) begin
                if (wcnt == 0) obs_addrs.push_back(mem_rd_addr);
                else if (mem_rd_addr !== last_addr) addr_stable = 0;
                last_addr = mem_rd_addr;
                mem_rd_data = mem[mem_rd_addr];
                if (wcnt == waits) begin mem_rd_valid = 1'b1; wcnt = 0; end
                else begin mem_rd_valid = 1'b0; wcnt++; end
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data = DW'($urandom);
            end
            if (poke) begin
                rti_req = 1'($urandom); ret_req = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_rd_valid = 1'b0; rti_req = 1'b0; ret_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_rd_req); end
        checks++; if ({pc_load, flags_load, sp_we, underflow_err} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {pc_load, flags_load, sp_we, underflow_err}); end
        checks++; if ({pc_out, flags_out, sp_out} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h want 0", pc_out, flags_out, sp_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sequence();
        int loads = 0;
        @(negedge clk);
        ret_req = 1'b1; sp_in = 11'h400;
        @(posedge clk); #1;
        ret_req = 1'b0; mem_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", stall); end
        rst_n = 1'b0;
        #1;
        checks++; if ({stall, mem_rd_req, pc_load, flags_load, sp_we, underflow_err} !== 6'b0) begin errors++; $display("FAIL midrst_outputs got %b want 000000", {stall, mem_rd_req, pc_load, flags_load, sp_we, underflow_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rd_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (pc_load || sp_we || stall || mem_rd_req) loads++;
        end
        mem_rd_valid = 1'b0;
        checks++; if (loads !== 0) begin errors++; $display("FAIL midrst_abandoned got %0d want 0", loads); end
    endtask

    task automatic test_ret_zero_wait();
        mem[11'h7FE] = 16'h0000; mem[11'h7FF] = 16'h0123;
        run_seq(1'b0, 1'b1, 11'h7FD, 0, 0);
        checks++; if (obs_addrs.size() != 2 || obs_addrs[0] !== 11'h7FE || obs_addrs[1] !== 11'h7FF) begin errors++; $display("FAIL ret_addrs got %p want 7fe,7ff", obs_addrs); end
        checks++; if (load_cyc != 3) begin errors++; $display("FAIL ret_latency got %0d want 3", load_cyc); end
        checks++; if (obs_pc !== 32'h0000_0123) begin errors++; $display("FAIL ret_pc got %h want 00000123", obs_pc); end
        checks++; if (obs_sp !== 11'h7FF || obs_we !== 1'b1) begin errors++; $display("FAIL ret_sp got %h/%b want 7ff/1", obs_sp, obs_we); end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL ret_stall got %0d want 3", stall_cnt); end
        checks++; if (obs_fl !== 1'b0 || fl_cnt != 0) begin errors++; $display("FAIL ret_flags_load got %b/%0d want 0/0", obs_fl, fl_cnt); end
    endtask

    task automatic test_rti();
        mem[11'h7FD] = 16'h0005; mem[11'h7FE] = 16'h0001; mem[11'h7FF] = 16'h0040;
        run_seq(1'b1, 1'b0, 11'h7FC, 0, 0);
        checks++; if (load_cyc != 4) begin errors++; $display("FAIL rti_latency got %0d want 4", load_cyc); end
        checks++; if (obs_flags !== 4'h5) begin errors++; $display("FAIL rti_flags got %h want 5", obs_flags); end
        checks++; if (obs_pc !== 32'h0001_0040) begin errors++; $display("FAIL rti_pc got %h want 00010040", obs_pc); end
        checks++; if (obs_sp !== 11'h7FF) begin errors++; $display("FAIL rti_sp got %h want 7ff", obs_sp); end
        checks++; if ({obs_fl, obs_we} !== 2'b11 || load_cnt != 1) begin errors++; $display("FAIL rti_strobes got %b%b x%0d want 11 x1", obs_fl, obs_we, load_cnt); end
    endtask

    task automatic test_wait_states();
        mem[11'h7FD] = 16'h0005; mem[11'h7FE] = 16'h0001; mem[11'h7FF] = 16'h0040;
        run_seq(1'b1, 1'b0, 11'h7FC, 2, 0);
        checks++; if (load_cyc != 10) begin errors++; $display("FAIL wait_latency got %0d want 10", load_cyc); end
        checks++; if (!addr_stable) begin errors++; $display("FAIL wait_addr_stable got 0 want 1"); end
        checks++; if (obs_addrs.size() != 3 || obs_addrs[0] !== 11'h7FD || obs_addrs[2] !== 11'h7FF) begin errors++; $display("FAIL wait_addrs got %p want 7fd,7fe,7ff", obs_addrs); end
        checks++; if ({obs_pc, obs_flags, obs_sp} !== {32'h0001_0040, 4'h5, 11'h7FF}) begin errors++; $display("FAIL wait_values got %h/%h/%h want 00010040/5/7ff", obs_pc, obs_flags, obs_sp); end
    endtask

    task automatic test_simultaneous();
        mem[11'h101] = 16'h000A; mem[11'h102] = 16'hBEEF; mem[11'h103] = 16'hCAFE;
        run_seq(1'b1, 1'b1, 11'h100, 1, 1);
        checks++; if (load_cyc != 7 || stall_cnt != 7) begin errors++; $display("FAIL simul_latency got %0d/%0d want 7/7", load_cyc, stall_cnt); end
        checks++; if ({obs_pc, obs_flags, obs_sp} !== {32'hBEEF_CAFE, 4'hA, 11'h103}) begin errors++; $display("FAIL simul_values got %h/%h/%h want beefcafe/a/103", obs_pc, obs_flags, obs_sp); end
        checks++; if (obs_fl !== 1'b1 || load_cnt != 1 || we_cnt != 1) begin errors++; $display("FAIL simul_strobes got %b/%0d/%0d want 1/1/1", obs_fl, load_cnt, we_cnt); end
    endtask

    task automatic test_underflow();
        mem[11'h7FF] = 16'h1234; mem[11'h000] = 16'h5678;
        run_seq(1'b0, 1'b1, 11'h7FE, 0, 0);
`ifdef STACK_UNDERFLOW_CHECK_EN
        checks++; if (obs_addrs.size() != 1 || obs_addrs[0] !== 11'h7FF) begin errors++; $display("FAIL uf_addrs got %p want 7ff", obs_addrs); end
        checks++; if (uf_cyc != 2) begin errors++; $display("FAIL uf_pulse got %0d want 2", uf_cyc); end
        checks++; if (load_cnt != 0 || we_cnt != 0 || fl_cnt != 0) begin errors++; $display("FAIL uf_no_load got %0d/%0d/%0d want 0/0/0", load_cnt, we_cnt, fl_cnt); end
`else
        checks++; if (obs_addrs.size() != 2 || obs_addrs[0] !== 11'h7FF || obs_addrs[1] !== 11'h000) begin errors++; $display("FAIL wrap_addrs got %p want 7ff,000", obs_addrs); end
        checks++; if (load_cyc != 3 || obs_sp !== 11'h000) begin errors++; $display("FAIL wrap_load got %0d/%h want 3/000", load_cyc, obs_sp); end
        checks++; if (obs_pc !== 32'h1234_5678 || uf_cyc != -1) begin errors++; $display("FAIL wrap_pc got %h/%0d want 12345678/-1", obs_pc, uf_cyc); end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            logic rti = (i == 1);
            logic [SW-1:0] sp = SW'(11'h200 + i * 16);
            model(rti, sp, 0);
            run_seq(rti, ~rti, sp, 0, 0);
            checks++; if (load_cyc != exp_end || obs_pc !== exp_pc || obs_sp !== exp_sp) begin errors++; $display("FAIL b2b_%0d got %0d/%h/%h want %0d/%h/%h", i, load_cyc, obs_pc, obs_sp, exp_end, exp_pc, exp_sp); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic rti = 1'($urandom);
            logic [SW-1:0] sp = (it % 8 == 0) ? SW'(11'h7FC + $urandom_range(0, 3)) : SW'($urandom);
            int waits = $urandom_range(0, 2);
            model(rti, sp, waits);
            run_seq(rti, 1'b1, sp, waits, 1'($urandom));
            checks++; if (stall_cnt != exp_end) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", it, stall_cnt, exp_end); end
            checks++; if (obs_addrs != exp_addrs || !addr_stable) begin errors++; $display("FAIL rnd%0d_addrs got %p want %p", it, obs_addrs, exp_addrs); end
            if (exp_uf) begin
                checks++; if (uf_cyc != exp_end || load_cnt != 0 || we_cnt != 0) begin errors++; $display("FAIL rnd%0d_uf got %0d/%0d/%0d want %0d/0/0", it, uf_cyc, load_cnt, we_cnt, exp_end); end
            end else begin
                checks++; if (load_cyc != exp_end || load_cnt != 1 || we_cnt != 1 || uf_cyc != -1) begin errors++; $display("FAIL rnd%0d_load got %0d/%0d/%0d want %0d/1/1", it, load_cyc, load_cnt, we_cnt, exp_end); end
                checks++; if (obs_pc !== exp_pc || obs_sp !== exp_sp) begin errors++; $display("FAIL rnd%0d_pcsp got %h/%h want %h/%h", it, obs_pc, obs_sp, exp_pc, exp_sp); end
                checks++; if (obs_fl !== rti || (rti && obs_flags !== exp_flags)) begin errors++; $display("FAIL rnd%0d_flags got %b/%h want %b/%h", it, obs_fl, obs_flags, rti, exp_flags); end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = DW'($urandom);
        test_reset();
        test_ret_zero_wait();
        test_rti();
        test_wait_states();
        test_simultaneous();
        test_underflow();
        test_back_to_back();
        test_reset_mid_sequence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
